// File: rtl/rag_csd_pkg.sv
// Shared types for the RAG context fetcher.
//   fetch_state_t : fetcher FSM states
//   meta_entry_t  : one metadata-table entry as it sits in the low 64 bits
//                   of a memory beat (addr in [31:0], length in [63:32])
package rag_csd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_META_RD,
      S_DATA_RD,
      S_OUT_HOLD,
      S_FINISH
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] length;
      logic [31:0] addr;
   } meta_entry_t;

endpackage

// File: rtl/doc_beat_calc.sv
// Combinational beat count for one document.
//   length : document length in bytes
//   beats  : ceil(length / BEAT_BYTES), clamped to MAX_DOC_BEATS
//   trunc  : high when the clamp was applied
// BEAT_BYTES must be a power of two.
module doc_beat_calc #(
   parameter int BEAT_BYTES    = 64,
   parameter int MAX_DOC_BEATS = 16,
   parameter int CNT_W         = 5
) (
   input  logic [31:0]      length,
   output logic [CNT_W-1:0] beats,
   output logic             trunc
);

   localparam int          SHIFT    = $clog2(BEAT_BYTES);
   localparam logic [31:0] REM_MASK = 32'(BEAT_BYTES - 1);

   logic [32:0] raw;

   // Shift-and-round-up avoids the (length + BEAT_BYTES - 1) overflow.
   always_comb begin
      raw   = {1'b0, length >> SHIFT} + {32'd0, |(length & REM_MASK)};
      trunc = raw > 33'(MAX_DOC_BEATS);
      beats = trunc ? CNT_W'(MAX_DOC_BEATS) : raw[CNT_W-1:0];
   end

endmodule

// File: rtl/context_fetcher.sv
// Fetches the documents of a ranked result set from memory.
// For each slot it reads the metadata entry (doc address + length), then
// streams the document one beat at a time to a valid/ready output, tagged
// with rank, index and score.
//   clk, rst             : clock, synchronous active-high reset
//   start/busy/done      : request handshake
//   num_results, metadata_addr_start, doc_indices, similarity_scores : query
//   mem_rd_*             : single-outstanding read port
//   out_*                : document beat stream
module context_fetcher
   import rag_csd_pkg::*;
#(
   parameter int TOP_K         = 5,
   parameter int BUS_WIDTH     = 512,
   parameter int MAX_DOC_BEATS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [31:0]           num_results,
   input  logic [31:0]           metadata_addr_start,
   input  logic [TOP_K*32-1:0]   doc_indices,
   input  logic [TOP_K*32-1:0]   similarity_scores,
   output logic                  mem_rd_en,
   output logic [31:0]           mem_rd_addr,
   input  logic [BUS_WIDTH-1:0]  mem_rd_data,
   input  logic                  mem_rd_valid,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BUS_WIDTH-1:0]  out_data,
   output logic [7:0]            out_rank,
   output logic [31:0]           out_doc_idx,
   output logic [31:0]           out_score,
   output logic                  out_last,
   output logic                  out_trunc
);

   localparam int BEAT_BYTES = BUS_WIDTH / 8;
   localparam int SHIFT      = $clog2(BEAT_BYTES);
   localparam int CNT_W      = $clog2(MAX_DOC_BEATS + 1);

   fetch_state_t state, nstate;

   logic [TOP_K*32-1:0]  idx_lat, score_lat;
   logic [31:0]          base_lat;
   logic [7:0]           slot, last_slot;
   logic [31:0]          cur_addr;
   logic [CNT_W-1:0]     total_beats, beat_num;
   logic                 trunc_lat;
   logic [BUS_WIDTH-1:0] data_lat;

   meta_entry_t          meta;
   logic [CNT_W-1:0]     calc_beats;
   logic                 calc_trunc;
   logic [31:0]          cur_idx, cur_score, n_sel;
   logic                 slot_is_last, beat_is_last;

   assign meta         = mem_rd_data[63:0];
   assign cur_idx      = idx_lat[32*int'(slot) +: 32];
   assign cur_score    = score_lat[32*int'(slot) +: 32];
   assign slot_is_last = (slot == last_slot);
   assign beat_is_last = (beat_num == total_beats - CNT_W'(1));
   assign n_sel        = (num_results == 32'd0 || num_results > 32'(TOP_K))
                         ? 32'(TOP_K) : num_results;

   doc_beat_calc #(
      .BEAT_BYTES    (BEAT_BYTES),
      .MAX_DOC_BEATS (MAX_DOC_BEATS),
      .CNT_W         (CNT_W)
   ) u_calc (
      .length (meta.length),
      .beats  (calc_beats),
      .trunc  (calc_trunc)
   );

   always_comb begin
      nstate = state;
      case (state)
         S_IDLE:     if (start) nstate = S_META_RD;
         S_META_RD:
            if (mem_rd_valid) begin
               if (calc_beats != '0) nstate = S_DATA_RD;
               else                  nstate = slot_is_last ? S_FINISH : S_META_RD;
            end
         S_DATA_RD:  if (mem_rd_valid) nstate = S_OUT_HOLD;
         S_OUT_HOLD:
            if (out_ready) begin
               if (!beat_is_last)     nstate = S_DATA_RD;
               else                   nstate = slot_is_last ? S_FINISH : S_META_RD;
            end
         S_FINISH:   nstate = S_IDLE;
         default:    nstate = S_IDLE;
      endcase
   end

   // All outputs decode from registered state, so reset clears them at once.
   always_comb begin
      busy        = (state == S_META_RD) || (state == S_DATA_RD) || (state == S_OUT_HOLD);
      done        = (state == S_FINISH);
      mem_rd_en   = (state == S_META_RD) || (state == S_DATA_RD);
      mem_rd_addr = '0;
      if (state == S_META_RD) mem_rd_addr = base_lat + (cur_idx << SHIFT);
      if (state == S_DATA_RD) mem_rd_addr = cur_addr;
      out_valid   = (state == S_OUT_HOLD);
      out_data    = out_valid ? data_lat  : '0;
      out_rank    = out_valid ? slot      : '0;
      out_doc_idx = out_valid ? cur_idx   : '0;
      out_score   = out_valid ? cur_score : '0;
      out_last    = out_valid && beat_is_last;
      out_trunc   = out_last && trunc_lat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx_lat     <= '0;
         score_lat   <= '0;
         base_lat    <= '0;
         slot        <= '0;
         last_slot   <= '0;
         cur_addr    <= '0;
         total_beats <= '0;
         beat_num    <= '0;
         trunc_lat   <= 1'b0;
         data_lat    <= '0;
      end else begin
         state <= nstate;
         case (state)
            S_IDLE:
               if (start) begin
                  idx_lat   <= doc_indices;
                  score_lat <= similarity_scores;
                  base_lat  <= metadata_addr_start;
                  slot      <= '0;
                  last_slot <= 8'(n_sel - 32'd1);
               end
            S_META_RD:
               if (mem_rd_valid) begin
                  cur_addr    <= meta.addr;
                  total_beats <= calc_beats;
                  trunc_lat   <= calc_trunc;
                  beat_num    <= '0;
                  if (calc_beats == '0 && !slot_is_last) slot <= slot + 8'd1;
               end
            S_DATA_RD:
               if (mem_rd_valid) data_lat <= mem_rd_data;
            S_OUT_HOLD:
               if (out_ready) begin
                  if (beat_is_last) begin
                     if (!slot_is_last) slot <= slot + 8'd1;
                  end else begin
                     beat_num <= beat_num + CNT_W'(1);
                     cur_addr <= cur_addr + 32'(BEAT_BYTES);
                  end
               end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_context_fetcher.sv
// Directed bench for context_fetcher: memory responder model, beat/read
// scoreboards, and a linear sequence of scenarios with hand-computed values.
module tb_context_fetcher;

   localparam int TOP_K = 5;
   localparam int BW    = 512;
   localparam logic [31:0] META_BASE = 32'h1000;
   localparam logic [31:0] DOC_BASE  = 32'h10_0000;

   logic            clk = 0, rst = 1, start = 0;
   logic            busy, done;
   logic [31:0]     num_results = 0, metadata_addr_start = META_BASE;
   logic [TOP_K*32-1:0] doc_indices = '0, similarity_scores = '0;
   logic            mem_rd_en;
   logic [31:0]     mem_rd_addr;
   logic [BW-1:0]   mem_rd_data;
   logic            mem_rd_valid;
   logic            out_valid, out_ready = 1;
   logic [BW-1:0]   out_data;
   logic [7:0]      out_rank;
   logic [31:0]     out_doc_idx, out_score;
   logic            out_last, out_trunc;

   context_fetcher #(.TOP_K(TOP_K), .BUS_WIDTH(BW), .MAX_DOC_BEATS(16)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .num_results(num_results), .metadata_addr_start(metadata_addr_start),
      .doc_indices(doc_indices), .similarity_scores(similarity_scores),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_rd_valid(mem_rd_valid), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rank(out_rank), .out_doc_idx(out_doc_idx),
      .out_score(out_score), .out_last(out_last), .out_trunc(out_trunc)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [31:0] len_tab [64];
   logic        resp_valid = 0, resp_off = 0, stray = 0;
   logic [BW-1:0] resp_data = '0;
   int          lat_cnt = 0;
   logic [31:0] rd_log [$];

   assign mem_rd_valid = resp_valid | stray;
   assign mem_rd_data  = resp_data;

   function automatic logic [BW-1:0] mem_model(input logic [31:0] a);
      logic [BW-1:0] d;
      logic [31:0]   i;
      d = '0;
      if (a >= META_BASE && a < META_BASE + 32'h1000) begin
         i = (a - META_BASE) >> 6;
         d[31:0]  = DOC_BASE + i * 32'h1_0000;
         d[63:32] = len_tab[i[5:0]];
      end else begin
         for (int k = 0; k < BW/32; k++) d[k*32 +: 32] = a;
      end
      return d;
   endfunction

   always @(posedge clk) begin
      if (rst || resp_off) begin
         resp_valid <= 0; lat_cnt <= 0;
      end else if (resp_valid) begin
         resp_valid <= 0; lat_cnt <= 0;
      end else if (mem_rd_en) begin
         if (lat_cnt == 1) begin
            resp_valid <= 1;
            resp_data  <= mem_model(mem_rd_addr);
            rd_log.push_back(mem_rd_addr);
            lat_cnt    <= 0;
         end else lat_cnt <= lat_cnt + 1;
      end
   end

   // ---------------- output scoreboard ----------------
   typedef struct {
      logic [7:0]  rank;
      logic [31:0] idx, score, data;
      logic        last, trunc;
   } beat_t;
   beat_t beats [$];
   int done_cnt = 0, viol = 0;

   always @(negedge clk) begin
      if (out_valid && out_ready)
         beats.push_back('{out_rank, out_doc_idx, out_score, out_data[31:0], out_last, out_trunc});
      if (done) done_cnt++;
      if (out_valid && mem_rd_en) viol++;
   end

   // ---------------- checking ----------------
   int n_chk = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input logic [31:0] nres);
      num_results = nres; start = 1; tick(); start = 0;
   endtask

   task automatic wait_done(input string tag);
      logic got;
      got = 0;
      for (int c = 0; c < 400; c++) begin
         if (done) begin got = 1; break; end
         tick();
      end
      chk({tag, "_done"}, got, 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      tick();
   endtask

   task automatic set_slot(input int s, input logic [31:0] idx, input logic [31:0] sc);
      doc_indices[s*32 +: 32]       = idx;
      similarity_scores[s*32 +: 32] = sc;
   endtask

   int nb, nr;
   logic [31:0] hold;
   int bad;
   logic found;

   initial begin
      for (int i = 0; i < 64; i++) len_tab[i] = 0;
      len_tab[7] = 128; len_tab[3] = 64; len_tab[9] = 2000;
      len_tab[2] = 64;  len_tab[4] = 0;  len_tab[6] = 65;
      len_tab[8] = 128; len_tab[5] = 256;

      repeat (3) tick();
      rst = 0; tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_rd_en", mem_rd_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data[63:0], 0);

      // S1: two docs, ready high
      set_slot(0, 7, 100); set_slot(1, 3, 200);
      nb = beats.size(); nr = rd_log.size();
      do_start(2);
      chk("s1_busy", busy, 1);
      chk("s1_meta_addr", mem_rd_addr, 32'h11C0);
      wait_done("s1");
      chk("s1_nbeats", beats.size() - nb, 3);
      chk("s1_b0", {beats[nb].rank, beats[nb].data, beats[nb].last},   {8'd0, 32'h170000, 1'b0});
      chk("s1_b0_tag", {beats[nb].idx, beats[nb].score}, {32'd7, 32'd100});
      chk("s1_b1", {beats[nb+1].rank, beats[nb+1].data, beats[nb+1].last}, {8'd0, 32'h170040, 1'b1});
      chk("s1_b2", {beats[nb+2].rank, beats[nb+2].data, beats[nb+2].last}, {8'd1, 32'h130000, 1'b1});
      chk("s1_b2_tag", {beats[nb+2].idx, beats[nb+2].score}, {32'd3, 32'd200});
      chk("s1_nreads", rd_log.size() - nr, 5);
      chk("s1_rd3", rd_log[nr+3], 32'h10C0);
      chk("s1_done_cnt", done_cnt, 1);

      // S2: num_results=0 -> TOP_K metadata reads, all zero length
      for (int s = 0; s < TOP_K; s++) set_slot(s, 10 + s, s);
      nb = beats.size(); nr = rd_log.size();
      do_start(0);
      wait_done("s2");
      chk("s2_nreads", rd_log.size() - nr, 5);
      chk("s2_rd0", rd_log[nr],   32'h1280);
      chk("s2_rd2", rd_log[nr+2], 32'h1300);
      chk("s2_rd4", rd_log[nr+4], 32'h1380);
      chk("s2_nbeats", beats.size() - nb, 0);

      // S3: 2000 bytes -> clamped to 16 beats; start while busy is ignored
      set_slot(0, 9, 55);
      nb = beats.size(); nr = rd_log.size();
      do_start(1);
      repeat (5) tick();
      num_results = 5; start = 1; tick(); start = 0;
      wait_done("s3");
      chk("s3_nbeats", beats.size() - nb, 16);
      chk("s3_b14", {beats[nb+14].last, beats[nb+14].trunc}, 2'b00);
      chk("s3_b15", {beats[nb+15].last, beats[nb+15].trunc, beats[nb+15].data}, {2'b11, 32'h1903C0});
      chk("s3_nreads", rd_log.size() - nr, 17);
      chk("s3_last_rd", rd_log[rd_log.size()-1], 32'h1903C0);

      // S4: zero length in slot 1
      set_slot(0, 2, 1); set_slot(1, 4, 2); set_slot(2, 6, 3);
      nb = beats.size(); nr = rd_log.size();
      do_start(3);
      wait_done("s4");
      chk("s4_nbeats", beats.size() - nb, 3);
      chk("s4_ranks", {beats[nb].rank, beats[nb+1].rank, beats[nb+2].rank}, {8'd0, 8'd2, 8'd2});
      chk("s4_b0", {beats[nb].last, beats[nb].data}, {1'b1, 32'h120000});
      chk("s4_b2", {beats[nb+2].last, beats[nb+2].trunc, beats[nb+2].data}, {2'b10, 32'h160040});
      chk("s4_nreads", rd_log.size() - nr, 6);

      // S5: consumer stall
      set_slot(0, 8, 9);
      nb = beats.size();
      out_ready = 0;
      do_start(1);
      found = 0;
      for (int c = 0; c < 100; c++) begin
         if (out_valid) begin found = 1; break; end
         tick();
      end
      chk("s5_out_valid", found, 1);
      hold = out_data[31:0];
      chk("s5_hold_data", hold, 32'h180000);
      bad = 0;
      repeat (10) begin
         tick();
         if (out_data[31:0] !== hold || mem_rd_en !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      chk("s5_stable", bad, 0);
      out_ready = 1;
      wait_done("s5");
      chk("s5_nbeats", beats.size() - nb, 2);

      // S6: reset during DATA_RD, stray valids, then a clean run
      set_slot(0, 5, 77);
      do_start(1);
      found = 0;
      for (int c = 0; c < 100; c++) begin
         if (mem_rd_en && mem_rd_addr == 32'h150000) begin found = 1; break; end
         tick();
      end
      chk("s6_in_data_rd", found, 1);
      nb = beats.size();
      resp_off = 1; rst = 1; stray = 1;
      tick();
      rst = 0; stray = 1;
      chk("s6_busy", busy, 0);
      chk("s6_outs", {mem_rd_en, out_valid, done, out_data[31:0], mem_rd_addr}, 0);
      tick(); stray = 0;
      tick(); tick();
      chk("s6_idle", {busy, mem_rd_en, out_valid}, 3'b000);
      chk("s6_no_beats", beats.size() - nb, 0);
      resp_off = 0;
      do_start(1);
      wait_done("s6b");
      chk("s6_nbeats", beats.size() - nb, 4);
      chk("s6_last", {beats[beats.size()-1].last, beats[beats.size()-1].data}, {1'b1, 32'h1500C0});

      chk("no_read_while_valid", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
